// File: rtl/mont_pkg.sv
// Shared types and constants for the radix-2 Montgomery multiplier.
package mont_pkg;

    localparam int DEFAULT_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        SUB,
        DONE
    } state_t;

    // Iteration counter width: ceil(log2(width)) + 1 bits.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mont_mul_radix2_if.sv
// Start/done multiplication handshake between the exponentiation controller
// (master) and the Montgomery multiplier (slave).
interface mont_mul_radix2_if
    import mont_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (
        output start, in_a, in_b, in_m,
        input  result, done
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output result, done
    );

endinterface

// File: rtl/mont_addsub.sv
// Shared accumulate adder; with MONT_FINAL_SUB_EN defined it also subtracts
// and reports a borrow for the final x >= y compare.
module mont_addsub
    import mont_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
`ifdef MONT_FINAL_SUB_EN
    input  logic         sub,
    output logic         borrow,
`endif
    output logic [N-1:0] sum
);

`ifdef MONT_FINAL_SUB_EN
    logic [N:0] full;

    // Subtraction as x + ~y + 1; the carry out is set exactly when x >= y.
    assign full   = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{N{1'b0}}, sub};
    assign sum    = full[N-1:0];
    assign borrow = ~full[N];
`else
    assign sum = x + y;
`endif

endmodule

// File: rtl/mont_mul_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Define MONT_FINAL_SUB_EN to keep the final subtraction (result < m).
module mont_mul_radix2
    import mont_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    mont_mul_radix2_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = WIDTH + 2;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, m_reg, result_reg;
    logic [AW-1:0]    c_reg, t, as_x, as_y, as_sum;
    logic [CW-1:0]    cnt;
    logic             done_reg, last_iter, accept;
`ifdef MONT_FINAL_SUB_EN
    logic             as_sub, as_borrow;
`endif

    assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign t         = c_reg + (a_reg[0] ? AW'(b_reg) : '0);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        as_x = t;
        as_y = t[0] ? AW'(m_reg) : '0;
`ifdef MONT_FINAL_SUB_EN
        as_sub = 1'b0;
        if (state == SUB) begin
            as_x   = c_reg;
            as_y   = AW'(m_reg);
            as_sub = 1'b1;
        end
`endif
    end

    mont_addsub #(.N(AW)) u_addsub (
        .x      (as_x),
        .y      (as_y),
`ifdef MONT_FINAL_SUB_EN
        .sub    (as_sub),
        .borrow (as_borrow),
`endif
        .sum    (as_sum)
    );

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (bus.start) state_next = LOOP;
`ifdef MONT_FINAL_SUB_EN
            LOOP:       if (last_iter) state_next = SUB;
            SUB:        state_next = DONE;
`else
            LOOP:       if (last_iter) state_next = DONE;
`endif
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_reg      <= '0;
            cnt        <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= (state_next == DONE);
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        c_reg <= '0;
                        cnt   <= '0;
                    end
                end
                LOOP: begin
                    c_reg <= as_sum >> 1;
                    cnt   <= cnt + CW'(1);
`ifndef MONT_FINAL_SUB_EN
                    // Lazy reduction: C < 2m already fits in WIDTH bits.
                    if (last_iter) result_reg <= as_sum[WIDTH:1];
`endif
                end
`ifdef MONT_FINAL_SUB_EN
                SUB: result_reg <= as_borrow ? c_reg[WIDTH-1:0] : as_sum[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            m_reg <= bus.in_m;
        end else if (state == LOOP) begin
            a_reg <= a_reg >> 1;
        end
    end

    assign bus.result = result_reg;
    assign bus.done   = done_reg;

endmodule

// File: tb/tb_mont_mul_radix2.sv
// Self-checking bench: directed WIDTH=8 vectors and handshake corner cases,
// plus randomized WIDTH=512 products against a reference model.
`timescale 1ns/1ps
module tb_mont_mul_radix2;

`ifdef MONT_FINAL_SUB_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 1;
`endif
    localparam int LAT8     = 8 + EXTRA;
    localparam int LAT512   = 512 + EXTRA;
    localparam int BOUND8   = 2 * 8 + 10;
    localparam int BOUND512 = 2 * 512 + 10;
    localparam int NV       = 12;
    localparam int NR       = 40;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] expv;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mont_mul_radix2_if #(.WIDTH(8))   bus8 ();
    mont_mul_radix2_if #(.WIDTH(512)) bus512 ();

    mont_mul_radix2 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    mont_mul_radix2 #(.WIDTH(512)) dut512 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus512)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // Exact match with the final subtraction; otherwise congruent and below 2m.
    task automatic check_result(input string name, input logic [1023:0] got,
                                input logic [1023:0] expv, input logic [1023:0] m);
`ifdef MONT_FINAL_SUB_EN
        check(name, got, expv);
`else
        check({name, "_mod"}, got % m, expv);
        check({name, "_lt2m"}, 1024'(got < (m << 1)), 1024'(1));
`endif
    endtask

    // a*b reduced first, then multiplied by 2^-w through w modular halvings.
    function automatic logic [1023:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                               input logic [1023:0] m, input int w);
        logic [1023:0] x;
        x = (a * b) % m;
        for (int i = 0; i < w; i++) x = x[0] ? ((x + m) >> 1) : (x >> 1);
        return x;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [7:0] va(input int k);
        return 8'((5 * k + 3) % 13);
    endfunction

    function automatic logic [7:0] vb(input int k);
        return 8'((7 * k + 1) % 13);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        output int lat, output logic [7:0] res);
        @(negedge clk);
        bus8.in_a = a; bus8.in_b = b; bus8.in_m = m; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.in_a = ~a; bus8.in_b = ~b; bus8.in_m = ~m;
        lat = 1;
        while (!bus8.done && lat < BOUND8) begin
            @(negedge clk);
            lat++;
        end
        if (!bus8.done) lat = -1;
        res = bus8.result;
    endtask

    task automatic run512(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                          output int lat, output logic [511:0] res);
        @(negedge clk);
        bus512.in_a = a; bus512.in_b = b; bus512.in_m = m; bus512.start = 1'b1;
        @(negedge clk);
        bus512.start = 1'b0;
        bus512.in_a = ~a; bus512.in_b = ~b; bus512.in_m = ~m;
        lat = 1;
        while (!bus512.done && lat < BOUND512) begin
            @(negedge clk);
            lat++;
        end
        if (!bus512.done) lat = -1;
        res = bus512.result;
    endtask

    initial begin
        vec_t          vecs [NV];
        int            lat;
        int            bad;
        logic [7:0]    res8;
        logic [7:0]    held;
        logic [511:0]  res512, m, a, b;

        n_checks = 0;
        n_pass   = 0;
        clk      = 1'b0;
        reset    = 1'b1;
        bus8.start = 1'b0;   bus8.in_a = '0;   bus8.in_b = '0;   bus8.in_m = '0;
        bus512.start = 1'b0; bus512.in_a = '0; bus512.in_b = '0; bus512.in_m = '0;

        vecs[0]  = '{a: 5,   b: 7,   m: 13,  expv: 1};
        vecs[1]  = '{a: 9,   b: 9,   m: 13,  expv: 9};
        vecs[2]  = '{a: 1,   b: 1,   m: 13,  expv: 3};
        vecs[3]  = '{a: 0,   b: 12,  m: 13,  expv: 0};
        vecs[4]  = '{a: 12,  b: 12,  m: 13,  expv: 3};
        vecs[5]  = '{a: 2,   b: 3,   m: 13,  expv: 5};
        vecs[6]  = '{a: 10,  b: 11,  m: 13,  expv: 5};
        vecs[7]  = '{a: 12,  b: 1,   m: 13,  expv: 10};
        vecs[8]  = '{a: 126, b: 126, m: 127, expv: 64};
        vecs[9]  = '{a: 1,   b: 1,   m: 127, expv: 64};
        vecs[10] = '{a: 2,   b: 2,   m: 3,   expv: 1};
        vecs[11] = '{a: 0,   b: 0,   m: 1,   expv: 0};

        repeat (2) @(negedge clk);
        check("rst_done8", 1024'(bus8.done), 0);
        check("rst_result8", 1024'(bus8.result), 0);
        check("rst_done512", 1024'(bus512.done), 0);
        check("rst_result512", 1024'(bus512.result), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done8", 1024'(bus8.done), 0);

        for (int i = 0; i < NV; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].m, lat, res8);
            check($sformatf("vec%0d_lat", i), 1024'(lat), 1024'(LAT8));
            check_result($sformatf("vec%0d", i), 1024'(res8), 1024'(vecs[i].expv), 1024'(vecs[i].m));
        end

        // DONE persists with start low and the result stays put.
        run8(8'd5, 8'd7, 8'd13, lat, res8);
        check("hold_lat", 1024'(lat), 1024'(LAT8));
        check_result("hold_first", 1024'(res8), 1024'(1), 1024'(13));
        held = res8;
        bad  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done !== 1'b1 || bus8.result !== held) bad++;
        end
        check("done_hold_20", 1024'(bad), 0);

        // start held high: back-to-back operations, done high one cycle each.
        @(negedge clk);
        bus8.in_m = 8'd13; bus8.in_a = va(0); bus8.in_b = vb(0); bus8.start = 1'b1;
        bad = 0;
        for (int k = 1; k <= 3 * LAT8; k++) begin
            @(negedge clk);
            if (k % LAT8 == 0) begin
                if (bus8.done !== 1'b1) bad++;
                check_result($sformatf("b2b_%0d", k / LAT8), 1024'(bus8.result),
                             mont_ref(1024'(va(k - LAT8)), 1024'(vb(k - LAT8)), 1024'(13), 8),
                             1024'(13));
            end else if (bus8.done !== 1'b0) begin
                bad++;
            end
            bus8.in_a = va(k);
            bus8.in_b = vb(k);
        end
        bus8.start = 1'b0;
        check("b2b_done_pattern", 1024'(bad), 0);

        // Reset in the middle of LOOP aborts the operation.
        @(negedge clk);
        bus8.in_a = 8'd5; bus8.in_b = 8'd7; bus8.in_m = 8'd13; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midloop_rst_done", 1024'(bus8.done), 0);
        check("midloop_rst_result", 1024'(bus8.result), 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (2 * LAT8) begin
            @(negedge clk);
            if (bus8.done !== 1'b0) bad++;
        end
        check("aborted_no_done", 1024'(bad), 0);
        run8(8'd5, 8'd7, 8'd13, lat, res8);
        check("after_rst_lat", 1024'(lat), 1024'(LAT8));
        check_result("after_rst", 1024'(res8), 1024'(1), 1024'(13));

        // WIDTH=512: largest legal modulus first, then random odd moduli.
        for (int i = 0; i < NR; i++) begin
            if (i == 0) begin
                m = {1'b0, {511{1'b1}}};
                a = m - 512'd1;
                b = m - 512'd1;
            end else begin
                m = rand512();
                m[511] = 1'b0;
                m[0]   = 1'b1;
                a = rand512() % m;
                b = rand512() % m;
            end
            run512(a, b, m, lat, res512);
            check($sformatf("w512_%0d_lat", i), 1024'(lat), 1024'(LAT512));
            check_result($sformatf("w512_%0d", i), 1024'(res512),
                         mont_ref(1024'(a), 1024'(b), 1024'(m), 512), 1024'(m));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
